// File: rtl/pe_pkg.sv
// Shared PE definitions: accumulator FSM states and signed saturation bounds.
package pe_pkg;

    typedef enum logic [1:0] {IDLE, SEED, ACCUM, DRAIN} acc_state_t;

    function automatic longint sat_max(input int unsigned width);
        return (longint'(1) <<< (width - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int unsigned width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// Window control, seed, product and result handshakes of the partial-sum stage.
interface psum_accumulator_if #(
    parameter int unsigned bitWidth   = 8,
    parameter int unsigned accWidth   = 16,
    parameter int unsigned countWidth = 8
);
    logic                       start;
    logic [countWidth-1:0]      cfg_len;
    logic                       cfg_use_psum;
    logic                       busy;

    logic signed [accWidth-1:0] psum_in;
    logic                       psum_in_valid;
    logic                       psum_in_ready;

    logic signed [bitWidth-1:0] prod;
    logic                       prod_valid;
    logic                       prod_ready;

    logic signed [accWidth-1:0] psum_out;
    logic                       psum_out_valid;
    logic                       psum_out_ready;
    logic                       sat_flag;

    modport master (
        output start, cfg_len, cfg_use_psum, psum_in, psum_in_valid, prod, prod_valid,
               psum_out_ready,
        input  busy, psum_in_ready, prod_ready, psum_out, psum_out_valid, sat_flag
    );

    modport slave (
        input  start, cfg_len, cfg_use_psum, psum_in, psum_in_valid, prod, prod_valid,
               psum_out_ready,
        output busy, psum_in_ready, prod_ready, psum_out, psum_out_valid, sat_flag
    );

endinterface

// File: rtl/saturating_adder.sv
// Combinational signed adder clamping to the width's range and flagging any clamp.
module saturating_adder
    import pe_pkg::*;
#(
    parameter int unsigned width = 16
) (
    input  logic signed [width-1:0] a,
    input  logic signed [width-1:0] b,
    output logic signed [width-1:0] sum,
    output logic                    overflow
);

    localparam logic signed [width-1:0] MaxVal = width'(sat_max(width));
    localparam logic signed [width-1:0] MinVal = width'(sat_min(width));

    logic signed [width:0] full;

    always_comb begin
        full     = (width + 1)'(a) + (width + 1)'(b);
        // One guard bit: the top two bits disagree exactly when the true sum left the range.
        overflow = full[width] != full[width-1];
        if (!overflow) begin
            sum = full[width-1:0];
        end else if (full[width]) begin
            sum = MinVal;
        end else begin
            sum = MaxVal;
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Windowed saturating partial-sum accumulator with optional seed from the PE above.
module psum_accumulator
    import pe_pkg::*;
#(
    parameter int unsigned bitWidth   = 8,
    parameter int unsigned accWidth   = 16,
    parameter int unsigned countWidth = 8
) (
    input logic              clk,
    input logic              rst,
    psum_accumulator_if.slave bus
);

    acc_state_t                 state_q, state_d;
    logic signed [accWidth-1:0] acc_q, acc_d;
    logic signed [accWidth-1:0] out_q, out_d;
    logic [countWidth-1:0]      len_q, len_d;
    logic [countWidth-1:0]      cnt_q, cnt_d;
    logic                       sat_q, sat_d;

    logic busy_q, prod_ready_q, psum_in_ready_q, out_valid_q;

    logic signed [accWidth-1:0] add_sum;
    logic                       add_ovf;
    logic                       prod_fire, seed_fire, out_fire;

    assign prod_fire = bus.prod_valid & prod_ready_q;
    assign seed_fire = bus.psum_in_valid & psum_in_ready_q;
    assign out_fire  = bus.psum_out_ready & out_valid_q;

    saturating_adder #(
        .width(accWidth)
    ) u_add (
        .a        (acc_q),
        .b        (accWidth'(bus.prod)),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        out_d   = out_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    len_d = bus.cfg_len;
                    acc_d = '0;
                    cnt_d = '0;
                    sat_d = 1'b0;
                    if (bus.cfg_use_psum) begin
                        state_d = SEED;
                    end else if (bus.cfg_len != '0) begin
                        state_d = ACCUM;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            SEED: begin
                if (seed_fire) begin
                    acc_d   = bus.psum_in;
                    state_d = (len_q != '0) ? ACCUM : DRAIN;
                end
            end
            ACCUM: begin
                if (prod_fire) begin
                    acc_d = add_sum;
                    sat_d = sat_q | add_ovf;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == len_q - 1'b1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Snapshot the result on DRAIN entry so psum_out survives the next window's clear.
        if (state_d == DRAIN && state_q != DRAIN) begin
            out_d = acc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            acc_q           <= '0;
            out_q           <= '0;
            len_q           <= '0;
            cnt_q           <= '0;
            sat_q           <= 1'b0;
            busy_q          <= 1'b0;
            prod_ready_q    <= 1'b0;
            psum_in_ready_q <= 1'b0;
            out_valid_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            acc_q           <= acc_d;
            out_q           <= out_d;
            len_q           <= len_d;
            cnt_q           <= cnt_d;
            sat_q           <= sat_d;
            busy_q          <= state_d != IDLE;
            prod_ready_q    <= state_d == ACCUM;
            psum_in_ready_q <= state_d == SEED;
            out_valid_q     <= state_d == DRAIN;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.prod_ready     = prod_ready_q;
    assign bus.psum_in_ready  = psum_in_ready_q;
    assign bus.psum_out_valid = out_valid_q;
    assign bus.psum_out       = out_q;
    assign bus.sat_flag       = sat_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized self-checking bench for psum_accumulator against an arithmetic window model.
module tb_psum_accumulator;

    logic clk;
    logic rst;

    psum_accumulator_if #(.bitWidth(8), .accWidth(16), .countWidth(8)) bus ();

    psum_accumulator #(
        .bitWidth   (8),
        .accWidth   (16),
        .countWidth (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int stim_q[$];

    // Expected result: seed (or 0) then clamp after every addition.
    function automatic void model(input bit use_seed, input int seed, input int len,
                                  output int res, output bit sat);
        longint acc;
        acc = use_seed ? longint'(seed) : 0;
        sat = 1'b0;
        for (int i = 0; i < len; i++) begin
            acc = acc + stim_q[i];
            if (acc > 32767) begin
                acc = 32767;
                sat = 1'b1;
            end else if (acc < -32768) begin
                acc = -32768;
                sat = 1'b1;
            end
        end
        res = int'(acc);
    endfunction

    // Runs one window starting at the current negedge; returns observations only.
    task automatic drive_window(input bit use_seed, input int seed, input int len,
                                input bit gaps, input int stall,
                                output int got, output bit got_sat, output bit [5:0] flags);
        int  n;
        int  idx;
        bit  accept;
        bit  tmo, early, stable, prompt, busy_ok, after_ok;
        logic signed [15:0] held;
        tmo = 0; early = 0; stable = 1;
        bus.start        = 1'b1;
        bus.cfg_len      = 8'(len);
        bus.cfg_use_psum = use_seed;
        @(negedge clk);
        bus.start        = 1'b0;
        bus.cfg_len      = 8'($urandom);
        bus.cfg_use_psum = 1'($urandom);
        busy_ok = bus.busy;
        if (use_seed) begin
            bus.psum_in       = 16'(seed);
            bus.psum_in_valid = 1'b1;
            n = 0;
            while (!bus.psum_in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) tmo = 1;
            @(negedge clk);
            bus.psum_in_valid = 1'b0;
            bus.psum_in       = 16'($urandom);
        end
        idx = 0; n = 0;
        while (idx < len && n < 400) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.prod_valid = 1'b0;
                bus.prod       = 8'($urandom);
            end else begin
                bus.prod_valid = 1'b1;
                bus.prod       = 8'(stim_q[idx]);
            end
            bus.start = 1'($urandom);
            if (bus.psum_out_valid) early = 1;
            accept = bus.prod_valid && bus.prod_ready;
            @(negedge clk);
            n++;
            if (accept) idx++;
        end
        if (n >= 400) tmo = 1;
        bus.prod_valid = 1'b0;
        bus.start      = 1'b0;
        prompt = bus.psum_out_valid;
        held   = bus.psum_out;
        for (int i = 0; i < stall; i++) begin
            if (!bus.psum_out_valid || bus.psum_out !== held || bus.prod_ready ||
                bus.psum_in_ready) stable = 0;
            @(negedge clk);
        end
        bus.psum_out_ready = 1'b1;
        n = 0;
        while (!bus.psum_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) tmo = 1;
        got     = int'(bus.psum_out);
        got_sat = bus.sat_flag;
        @(negedge clk);
        bus.psum_out_ready = 1'b0;
        after_ok = !bus.psum_out_valid && !bus.busy && (bus.psum_out === 16'(got));
        flags = {prompt, early, tmo, busy_ok, after_ok, stable};
    endtask

    // flags expected: prompt=1, early=0, tmo=0, busy_ok=1, after_ok=1, stable=1
    localparam bit [5:0] FlagsOk = 6'b100111;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.prod_ready, bus.psum_in_ready, bus.psum_out_valid, bus.sat_flag}
            !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 00000", {bus.busy, bus.prod_ready,
                     bus.psum_in_ready, bus.psum_out_valid, bus.sat_flag});
        end
        n_checks++;
        if (bus.psum_out !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset_psum_out: got %0d required 0", bus.psum_out);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.prod_ready, bus.psum_in_ready, bus.psum_out_valid} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b required 0000", {bus.busy,
                     bus.prod_ready, bus.psum_in_ready, bus.psum_out_valid});
        end
    endtask

    task automatic test_directed(input string name, input bit use_seed, input int seed,
                                 input bit gaps, input int stall, input int exp_res,
                                 input bit exp_sat);
        int got, mres;
        bit gsat, msat;
        bit [5:0] flags;
        model(use_seed, seed, stim_q.size(), mres, msat);
        drive_window(use_seed, seed, stim_q.size(), gaps, stall, got, gsat, flags);
        n_checks++;
        if (got !== exp_res || gsat !== exp_sat || mres !== exp_res || msat !== exp_sat) begin
            n_fail++;
            $display("FAIL %s_result: got %0d sat %0b, required %0d sat %0b", name, got, gsat,
                     exp_res, exp_sat);
        end
        n_checks++;
        if (flags !== FlagsOk) begin
            n_fail++;
            $display("FAIL %s_timing: flags %b required %b", name, flags, FlagsOk);
        end
    endtask

    task automatic test_reset_mid_window();
        bit quiet;
        bus.start = 1'b1; bus.cfg_len = 8'd4; bus.cfg_use_psum = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.prod_valid = 1'b1; bus.prod = 8'sd3;
        @(negedge clk);
        bus.prod = 8'sd4;
        @(negedge clk);
        bus.prod_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.busy, bus.prod_ready, bus.psum_out_valid, bus.sat_flag} !== 4'b0 ||
            bus.psum_out !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset_mid_accum: ctrl %b out %0d required 0000 and 0",
                     {bus.busy, bus.prod_ready, bus.psum_out_valid, bus.sat_flag},
                     bus.psum_out);
        end
        @(negedge clk);
        rst = 1'b0;
        quiet = 1;
        repeat (4) begin
            @(negedge clk);
            if (bus.psum_out_valid || bus.busy) quiet = 0;
        end
        n_checks++;
        if (quiet !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_no_output: got quiet=%0b required 1", quiet);
        end
    endtask

    task automatic test_back_to_back_random();
        int got, mres, seed, len, stall;
        bit gsat, msat, use_seed;
        bit [5:0] flags;
        for (int w = 0; w < 24; w++) begin
            use_seed = 1'($urandom);
            seed     = int'($urandom_range(0, 65535)) - 32768;
            if (w % 4 == 0) seed = (w % 8 == 0) ? 32700 : -32700;
            len      = int'($urandom_range(0, 12));
            stall    = int'($urandom_range(0, 3));
            stim_q.delete();
            for (int i = 0; i < len; i++) begin
                stim_q.push_back(int'($urandom_range(0, 255)) - 128);
            end
            model(use_seed, seed, len, mres, msat);
            drive_window(use_seed, seed, len, 1'b1, stall, got, gsat, flags);
            n_checks++;
            if (got !== mres || gsat !== msat) begin
                n_fail++;
                $display("FAIL random_w%0d_result: got %0d sat %0b, required %0d sat %0b",
                         w, got, gsat, mres, msat);
            end
            n_checks++;
            if (flags !== FlagsOk) begin
                n_fail++;
                $display("FAIL random_w%0d_timing: flags %b required %b", w, flags, FlagsOk);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.cfg_len = '0; bus.cfg_use_psum = 1'b0;
        bus.psum_in = '0; bus.psum_in_valid = 1'b0;
        bus.prod = '0; bus.prod_valid = 1'b0;
        bus.psum_out_ready = 1'b0;

        test_reset();

        stim_q = '{10, 20, -5, 7};
        test_directed("basic", 1'b0, 0, 1'b0, 0, 32, 1'b0);
        stim_q = '{5, 5};
        test_directed("pos_sat", 1'b1, 32760, 1'b0, 0, 32767, 1'b1);
        stim_q = '{-1, 1};
        test_directed("neg_rail", 1'b1, -32768, 1'b0, 0, -32767, 1'b1);
        stim_q = '{1, 2, 3};
        test_directed("backpressure", 1'b0, 0, 1'b1, 3, 6, 1'b0);
        stim_q.delete();
        test_directed("len0_seed", 1'b1, 100, 1'b0, 0, 100, 1'b0);
        test_directed("len0_noseed", 1'b0, 0, 1'b0, 1, 0, 1'b0);

        test_reset_mid_window();
        stim_q = '{9};
        test_directed("after_reset", 1'b0, 0, 1'b0, 0, 9, 1'b0);

        test_back_to_back_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
